// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry for the direct-mapped data cache
package dcache_pkg;

    localparam int LINE_W         = 256;
    localparam int WORDS_PER_LINE = 8;
    localparam int OFFSET_W       = 3;
    localparam int BYTE_OFF_W     = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } state_t;

    function automatic int tag_width(input int addr_w, input int idx_w);
        return addr_w - idx_w - BYTE_OFF_W;
    endfunction

endpackage

// File: rtl/dcache_store.sv
// rtl/dcache_store.sv - tag/valid/dirty/data arrays, async read, single write port
module dcache_store
    import dcache_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 22,
    parameter int LINE_W = dcache_pkg::LINE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IDX_W-1:0]    index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [LINE_W-1:0]   rd_line,
    input  logic                line_we,
    input  logic [TAG_W-1:0]    line_tag,
    input  logic [LINE_W-1:0]   line_data,
    input  logic                word_we,
    input  logic [OFFSET_W-1:0] word_off,
    input  logic [31:0]         word_data
);

    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0]  valid_bits;
    logic [LINES-1:0]  dirty_bits;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    assign rd_valid = valid_bits[index];
    assign rd_dirty = dirty_bits[index];
    assign rd_tag   = tag_mem[index];
    assign rd_line  = data_mem[index];

    // Only the status bits are cleared by reset; tag/data are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (line_we) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
        end else if (word_we) begin
            dirty_bits[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[index]  <= line_tag;
            data_mem[index] <= line_data;
        end else if (word_we) begin
            data_mem[index][{word_off, 5'b00000} +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate data cache controller
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int LINE_W = dcache_pkg::LINE_W,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_mem_read_i,
    input  logic              p1_mem_write_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int TAG_W = tag_width(ADDR_W, IDX_W);

    state_t              state, state_next;
    logic                req, hit;
    logic [IDX_W-1:0]    index;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] offset;
    logic                rd_valid, rd_dirty;
    logic [TAG_W-1:0]    rd_tag;
    logic [LINE_W-1:0]   rd_line;
    logic                line_we, word_we;
    logic                unused_addr_bits;

    assign req    = p1_mem_read_i | p1_mem_write_i;
    assign offset = p1_addr_i[BYTE_OFF_W-1:2];
    assign index  = p1_addr_i[BYTE_OFF_W +: IDX_W];
    assign tag    = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign hit    = req & rd_valid & (rd_tag == tag);
    assign unused_addr_bits = &{1'b0, p1_addr_i[1:0]};

    assign p1_data_o = hit ? rd_line[{offset, 5'b00000} +: 32] : 32'h0;

    dcache_store #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (index),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .line_we   (line_we),
        .line_tag  (tag),
        .line_data (mem_data_i),
        .word_we   (word_we),
        .word_off  (offset),
        .word_data (p1_data_i)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req && !hit) state_next = (rd_valid && rd_dirty) ? WB : REFILL;
            WB:      if (mem_ack_i)   state_next = REFILL;
            REFILL:  if (mem_ack_i)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // The request address is held by the stall, so it still names the missing line here.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        p1_stall_o   = 1'b1;
        line_we      = 1'b0;
        word_we      = 1'b0;
        unique case (state)
            IDLE: begin
                p1_stall_o = req & ~hit;
                word_we    = hit & p1_mem_write_i;
            end
            WB: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_tag, index, {BYTE_OFF_W{1'b0}}};
                mem_data_o   = rd_line;
            end
            REFILL: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {tag, index, {BYTE_OFF_W{1'b0}}};
                line_we      = mem_ack_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  p1_addr_i, p1_data_i, p1_data_o;
    logic         p1_mem_read_i, p1_mem_write_i, p1_stall_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         resp_ack, spur_ack, mem_ack;

    assign mem_ack = resp_ack | spur_ack;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p1_addr_i      (p1_addr_i),
        .p1_data_i      (p1_data_i),
        .p1_mem_read_i  (p1_mem_read_i),
        .p1_mem_write_i (p1_mem_write_i),
        .p1_data_o      (p1_data_o),
        .p1_stall_o     (p1_stall_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack)
    );

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat_wb;
        int          lat_rf;
        int          exp_stall;
        logic        chk_data;
        logic [31:0] exp_data;
        int          exp_ntxn;
        logic        exp_wr0;
        logic [31:0] exp_addr0;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          lat_wb = 1;
    int          lat_rf = 1;
    txn_t        txn_q[$];
    logic [31:0] backing [bit [31:0]];
    logic [31:0] arch    [bit [31:0]];
    vec_t        vecs [10];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a == 32'h48) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000) + 32'h1357;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : init_word(a);
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory side: after seeing a request, waits lat_* cycles then answers with a one-cycle ack.
    initial begin : responder
        bit   busy;
        int   wait_cnt;
        txn_t t;
        busy = 1'b0;
        wait_cnt = 0;
        resp_ack = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else begin
                if (mem_enable_o && !busy) begin
                    busy = 1'b1;
                    wait_cnt = mem_write_o ? lat_wb : lat_rf;
                end
                if (busy) begin
                    if (wait_cnt == 0) begin
                        t.wr = mem_write_o;
                        t.addr = mem_addr_o;
                        t.data = mem_data_o;
                        for (int w = 0; w < 8; w++) begin
                            if (mem_write_o) backing[mem_addr_o + 32'(w * 4)] = mem_data_o[32*w +: 32];
                            else mem_data_i[32*w +: 32] = mem_rd(mem_addr_o + 32'(w * 4));
                        end
                        txn_q.push_back(t);
                        resp_ack = 1'b1;
                        busy = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output int stalls,
                          output logic [31:0] rdata, output logic timed_out);
        @(posedge clk);
        #1;
        txn_q.delete();
        p1_mem_read_i = rd;
        p1_mem_write_i = wr;
        p1_addr_i = addr;
        p1_data_i = wdata;
        stalls = 0;
        @(negedge clk);
        while (p1_stall_o && stalls < 300) begin
            stalls++;
            @(negedge clk);
        end
        timed_out = p1_stall_o;
        rdata = p1_data_o;
        @(posedge clk);
        #1;
        p1_mem_read_i = 1'b0;
        p1_mem_write_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : main
        int          stalls;
        logic [31:0] rdata;
        logic        to;
        vec_t        v;
        int          mvalid [4];
        int          mtag   [4];
        int          mdirty [4];

        spur_ack = 1'b0;
        p1_addr_i = '0;
        p1_data_i = '0;
        p1_mem_read_i = 1'b0;
        p1_mem_write_i = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(p1_stall_o), 0);
        check("rst_enable", 32'(mem_enable_o), 0);
        check("rst_write", 32'(mem_write_o), 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_mdata", mem_data_o[31:0] | mem_data_o[255:224], 0);
        check("rst_pdata", p1_data_o, 0);
        p1_addr_i = 32'h40;
        p1_mem_read_i = 1'b1;
        #1;
        check("rst_stall_req", 32'(p1_stall_o), 1);
        p1_mem_read_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,         1, 4, 6,  1'b1, 32'hC0DE_1397, 1, 1'b0, 32'h40};
        vecs[1] = '{1'b1, 1'b0, 32'h48,  32'h0,         1, 1, 0,  1'b1, 32'hDEAD_BEEF, 0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 32'h44,  32'h1234_5678, 1, 1, 0,  1'b0, 32'h0,         0, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 32'h44,  32'h0,         1, 1, 0,  1'b1, 32'h1234_5678, 0, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 32'h444, 32'h0,         3, 4, 10, 1'b1, 32'hC0DE_179B, 2, 1'b1, 32'h40};
        vecs[5] = '{1'b0, 1'b1, 32'h80,  32'hAAAA_5555, 1, 2, 4,  1'b0, 32'h0,         1, 1'b0, 32'h80};
        vecs[6] = '{1'b1, 1'b0, 32'h80,  32'h0,         1, 1, 0,  1'b1, 32'hAAAA_5555, 0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h84,  32'h0BAD_F00D, 1, 1, 0,  1'b0, 32'h0,         0, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 1'b0, 32'h84,  32'h0,         1, 1, 0,  1'b1, 32'h0BAD_F00D, 0, 1'b0, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 32'h44,  32'h0,         2, 1, 3,  1'b1, 32'h1234_5678, 1, 1'b0, 32'h40};

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            lat_wb = v.lat_wb;
            lat_rf = v.lat_rf;
            access(v.rd, v.wr, v.addr, v.wdata, stalls, rdata, to);
            check($sformatf("vec%0d_timeout", i), 32'(to), 0);
            check($sformatf("vec%0d_stall", i), 32'(stalls), 32'(v.exp_stall));
            if (v.chk_data) check($sformatf("vec%0d_data", i), rdata, v.exp_data);
            check($sformatf("vec%0d_ntxn", i), 32'(txn_q.size()), 32'(v.exp_ntxn));
            if (v.exp_ntxn > 0 && txn_q.size() > 0) begin
                check($sformatf("vec%0d_wr0", i), 32'(txn_q[0].wr), 32'(v.exp_wr0));
                check($sformatf("vec%0d_addr0", i), txn_q[0].addr, v.exp_addr0);
            end
            if (i == 4 && txn_q.size() == 2) begin
                check("vec4_wb_word1", txn_q[0].data[63:32], 32'h1234_5678);
                check("vec4_wb_word2", txn_q[0].data[95:64], 32'hDEAD_BEEF);
                check("vec4_rf_write", 32'(txn_q[1].wr), 0);
                check("vec4_rf_addr", txn_q[1].addr, 32'h440);
            end
        end

        // Reset asserted while a refill is outstanding.
        @(posedge clk);
        #1;
        lat_rf = 10;
        p1_addr_i = 32'h100;
        p1_mem_read_i = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_refill_enable", 32'(mem_enable_o), 1);
        check("mid_refill_write", 32'(mem_write_o), 0);
        check("mid_refill_addr", mem_addr_o, 32'h100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_enable", 32'(mem_enable_o), 0);
        check("async_rst_stall_req", 32'(p1_stall_o), 1);
        check("async_rst_pdata", p1_data_o, 0);
        p1_mem_read_i = 1'b0;
        #1;
        check("async_rst_stall_idle", 32'(p1_stall_o), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lat_rf = 3;
        access(1'b1, 1'b0, 32'h40, 32'h0, stalls, rdata, to);
        check("post_rst_timeout", 32'(to), 0);
        check("post_rst_miss_stall", 32'(stalls), 5);
        check("post_rst_data", rdata, 32'hC0DE_1397);

        // Ack pulse while idle must be ignored.
        @(posedge clk);
        #1;
        p1_addr_i = 32'h44;
        spur_ack = 1'b1;
        @(posedge clk);
        #1;
        spur_ack = 1'b0;
        @(negedge clk);
        check("spur_ack_enable", 32'(mem_enable_o), 0);
        access(1'b1, 1'b0, 32'h44, 32'h0, stalls, rdata, to);
        check("spur_ack_stall", 32'(stalls), 0);
        check("spur_ack_data", rdata, 32'h1234_5678);

        // Randomized traffic over 4 indices x 3 tags against a flat memory model.
        do_reset();
        arch = backing;
        for (int k = 0; k < 4; k++) begin
            mvalid[k] = 0;
            mtag[k] = 0;
            mdirty[k] = 0;
        end
        for (int n = 0; n < 150; n++) begin
            int          t, ix, kind, exp_stall;
            logic [31:0] addr, waddr, wdata, exp_data;
            logic        rd, wr;
            t = $urandom_range(0, 2);
            ix = $urandom_range(0, 3);
            kind = $urandom_range(0, 3);
            addr = 32'((t << 10) | (ix << 5) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            waddr = addr & 32'hFFFF_FFFC;
            wdata = $urandom;
            rd = (kind != 2);
            wr = (kind >= 2);
            lat_wb = $urandom_range(1, 4);
            lat_rf = $urandom_range(1, 4);
            exp_data = arch_rd(waddr);
            if (mvalid[ix] == 1 && mtag[ix] == t) begin
                exp_stall = 0;
            end else begin
                exp_stall = 1 + ((mvalid[ix] == 1 && mdirty[ix] == 1) ? lat_wb + 1 : 0) + lat_rf + 1;
                mvalid[ix] = 1;
                mtag[ix] = t;
                mdirty[ix] = 0;
            end
            if (wr) begin
                arch[waddr] = wdata;
                mdirty[ix] = 1;
            end
            access(rd, wr, addr, wdata, stalls, rdata, to);
            check($sformatf("rnd%0d_stall", n), 32'(stalls), 32'(exp_stall));
            if (!wr) check($sformatf("rnd%0d_data", n), rdata, exp_data);
            if (to) break;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
